dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-side memory responder for the single-cycle RISC-V core: serves the core's load/store port (address, write data, write strobe, read data) with a word-addressed data RAM plus a small memory-mapped I/O window. Reads return combinationally within the core's single cycle; stores commit on the clock edge. The MMIO window holds an LED register, a free-running cycle counter and a console transmit FIFO drained over a valid/ready byte interface.

## Interface
- DEPTH, 1024: RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: console FIFO entries; power of two, 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_w  in  1  store strobe from core; write takes effect at the next rising edge.
- addr  in  32  byte address from core ALU output.
- wdata  in  32  store data from core.
- rdata  out  32  load data to core; combinational.
- led  out  16  LED register.
- tx_data  out  8  console byte at FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts the byte this cycle.

## Operation
- Decode: addr[31:16]==16'hFFFF selects MMIO; all other addresses select RAM, index addr[log2(DEPTH)+1:2] (aliases modulo DEPTH). addr[1:0] ignored everywhere; all accesses are full-word.
- RAM: rdata = ram[index]; mem_w writes wdata at index. RAM contents not reset.
- MMIO map (offset = addr[15:0]):
  - 0x0000 LED: read {16'b0, led}; write led <= wdata[15:0].
  - 0x0004 CYCLE: read counter; write loads wdata.
  - 0x0008 TXDATA: read 0; write pushes wdata[7:0].
  - 0x000C STATUS: read {11'b0, count[4:0], 13'b0, overflow, full, empty} (count at [20:16], overflow bit 2, full bit 1, empty bit 0); any write clears overflow.
  - Other offsets: read 0, write ignored.
- Cycle counter: 32-bit, +1 each cycle, wraps 0xFFFFFFFF -> 0. A write cycle loads wdata instead of incrementing; next cycle continues from wdata+1.
- Console FIFO: circular buffer, read/write pointers plus count (0..FIFO_DEPTH).
  - pop = tx_valid & tx_ready; tx_data = entry at read pointer; tx_valid = (count != 0).
  - push = store to TXDATA; accepted if count < FIFO_DEPTH or pop in the same cycle.
  - Push when full with no pop: byte dropped, overflow <= 1 (sticky). Overflow-set and STATUS-write in same cycle: clear wins.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - tx_data is don't-care while tx_valid=0; sink must not rely on it.

## Timing
- Reset (reset=0, asynchronous): led=0, counter=0, FIFO empty (count=0, pointers 0), overflow=0, tx_valid=0. rdata reflects RAM/MMIO decode combinationally, no reset value of its own.
- Load latency 0: rdata valid in same cycle as addr.
- Store visible to loads from the cycle after the edge; a load of the address being stored in the same cycle returns old data.
- TXDATA push visible on tx_valid/tx_data and STATUS from the next cycle.
- tx_data/tx_valid hold stable while tx_valid=1 and tx_ready=0.
- Reset mid-transfer: FIFO contents discarded, tx_valid drops immediately.

## Configuration
- DMEM_CYCLE_CNT_EN defined: cycle counter present as described.
- Not defined: counter logic removed; CYCLE reads 0, writes ignored; all other behaviour unchanged.

## Test plan
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and alias 0x0000_1010 (DEPTH=1024) -> both return 0xDEADBEEF; same-cycle load during store returns prior value.
- Store 0x1234ABCD to 0xFFFF0000 -> led=0xABCD, load returns 0x0000ABCD; reset low -> led=0 immediately.
- Release reset, load CYCLE after 10 cycles -> 10; store 0xFFFFFFFE, load 2 cycles later -> 0x00000000 (wrap). Without DMEM_CYCLE_CNT_EN -> always 0.
- tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x00040006 (count 4, full, overflow); raise tx_ready -> tx_data 0x41..0x44 on consecutive cycles, then tx_valid=0, STATUS=0x00000005; write STATUS -> 0x00000001.
- FIFO full, tx_ready=1, push 0x55 same cycle -> accepted, count stays 4, no overflow; 0x55 emerges after the three older bytes.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder: data RAM plus MMIO (LED, cycle counter, console TX FIFO).
// Optional: DMEM_CYCLE_CNT_EN enables the free-running cycle counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] FULL_CNT = 5'(FIFO_DEPTH);

  logic          is_mmio;
  logic [13:0]   reg_sel;
  logic          sel_led, sel_cycle, sel_tx, sel_status;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_lsb;

  assign is_mmio    = (addr[31:16] == 16'hFFFF);
  assign reg_sel    = addr[15:2];
  assign sel_led    = is_mmio && (reg_sel == 14'd0);
  assign sel_cycle  = is_mmio && (reg_sel == 14'd1);
  assign sel_tx     = is_mmio && (reg_sel == 14'd2);
  assign sel_status = is_mmio && (reg_sel == 14'd3);
  assign ram_idx    = addr[AW+1:2];
  assign unused_addr_lsb = ^addr[1:0];

  logic [31:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_w && !is_mmio) ram[ram_idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 led <= '0;
    else if (mem_w && sel_led)  led <= wdata[15:0];
  end

  logic [31:0] cycle_rd;
`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cycle_cnt <= '0;
    else if (mem_w && sel_cycle) cycle_cnt <= wdata;
    else                         cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic          empty, full, pop, push, push_ok, drop;

  assign empty    = (count == 5'd0);
  assign full     = (count == FULL_CNT);
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push     = mem_w && sel_tx;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {4'b0, push_ok} - {4'b0, pop};
      if (mem_w && sel_status) overflow <= 1'b0;
      else if (drop)           overflow <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (is_mmio) begin
      if (sel_led)         rdata = {16'b0, led};
      else if (sel_cycle)  rdata = cycle_rd;
      else if (sel_status) rdata = {11'b0, count, 13'b0, overflow, full, empty};
    end else begin
      rdata = ram[ram_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_responder: directed table, corner sequences and random traffic
// checked against a queue/array reference model. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int FD    = 4;
`ifdef DMEM_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_TX     = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  logic [15:0] m_led;
  logic [31:0] m_cnt;
  bit          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_led = '0;
    m_cnt = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    known = 1'b1;
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:2])
        14'd0:   return {16'b0, m_led};
        14'd1:   return CNT_EN ? m_cnt : 32'd0;
        14'd3:   return {11'b0, 5'(m_q.size()), 13'b0, m_ovf, m_q.size() == FD, m_q.size() == 0};
        default: return 32'd0;
      endcase
    end
    if (m_ram.exists(int'(a[11:2]))) return m_ram[int'(a[11:2])];
    known = 1'b0;
    return 32'd0;
  endfunction

  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    bit mm, pop, push, accept;
    logic [13:0] s;
    mm     = (a[31:16] == 16'hFFFF);
    s      = a[15:2];
    pop    = (m_q.size() != 0) && r;
    push   = w && mm && (s == 14'd2);
    accept = push && ((m_q.size() < FD) || pop);
    if (pop) void'(m_q.pop_front());
    if (accept) m_q.push_back(d[7:0]);
    if (push && !accept) m_ovf = 1'b1;
    if (w && mm && s == 14'd3) m_ovf = 1'b0;
    if (w && mm && s == 14'd0) m_led = d[15:0];
    if (w && mm && s == 14'd1) m_cnt = d;
    else                       m_cnt = m_cnt + 32'd1;
    if (w && !mm) m_ram[int'(a[11:2])] = d;
  endtask

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    bit known;
    logic [31:0] exp;
    mem_w = w; addr = a; wdata = d; tx_ready = r;
    #1;
    exp = m_read(a, known);
    if (known) check("model_rdata", rdata, exp);
    check("model_tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) check("model_tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
    check("model_led", {16'b0, led}, {16'b0, m_led});
    @(posedge clk);
    m_step(w, a, d, r);
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    mem_w = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] exp);
    #1;
    check({name, "_valid"}, {31'b0, tx_valid}, 32'd1);
    check({name, "_data"}, {24'b0, tx_data}, {24'b0, exp});
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 32'h0000_1012, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 32'h0000_1014, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'hCAFE_F00D};
    tbl[7]  = '{1'b1, A_LED,         32'h1234_ABCD, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, A_LED,         32'h0,         1'b1, 32'h0000_ABCD};
    tbl[9]  = '{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'hFFFF_0010, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'hFFFF_0003, 32'h0,         1'b1, 32'h0000_ABCD};
    tbl[12] = '{1'b0, A_TX,          32'h0,         1'b1, 32'h0};
    tbl[13] = '{1'b0, 32'hFFFE_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};

    reset = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    peek("rst_status", A_STATUS, 32'h0000_0001);
    peek("rst_cycle", A_CYCLE, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_reset();

    for (int i = 0; i < 14; i++) begin
      mem_w = tbl[i].w; addr = tbl[i].a; wdata = tbl[i].d; tx_ready = 1'b0;
      #1;
      if (tbl[i].chk) check($sformatf("vec%0d", i), rdata, tbl[i].exp);
      cyc(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0);
    end
    check("led_abcd", {16'b0, led}, 32'h0000_ABCD);

    // Asynchronous reset drops LED immediately, then the counter restarts.
    reset = 1'b0;
    #1;
    check("async_rst_led", {16'b0, led}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_reset();
    repeat (10) cyc(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    peek("cycle_10", A_CYCLE, CNT_EN ? 32'd10 : 32'd0);
    cyc(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
    cyc(1'b0, A_CYCLE, 32'h0, 1'b0);
    peek("cycle_ffffffff", A_CYCLE, CNT_EN ? 32'hFFFF_FFFF : 32'd0);
    cyc(1'b0, A_CYCLE, 32'h0, 1'b0);
    peek("cycle_wrap", A_CYCLE, 32'h0);

    // Fill past capacity, then drain.
    for (int i = 0; i < 5; i++) cyc(1'b1, A_TX, 32'h41 + i, 1'b0);
    peek("status_ovf", A_STATUS, 32'h0004_0006);
    expect_tx("hold", 8'h41);
    cyc(1'b0, A_STATUS, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_tx($sformatf("drain%0d", i), 8'h41 + 8'(i));
      cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    end
    check("drained_valid", {31'b0, tx_valid}, 32'h0);
    peek("status_drained", A_STATUS, 32'h0000_0005);
    cyc(1'b1, A_STATUS, 32'h0, 1'b0);
    peek("status_cleared", A_STATUS, 32'h0000_0001);

    // Push into a full FIFO while it is popping.
    for (int i = 0; i < 4; i++) cyc(1'b1, A_TX, 32'h61 + i, 1'b0);
    peek("status_full", A_STATUS, 32'h0004_0002);
    cyc(1'b1, A_TX, 32'h55, 1'b1);
    peek("status_full_pp", A_STATUS, 32'h0004_0002);
    expect_tx("pp0", 8'h62); cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    expect_tx("pp1", 8'h63); cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    expect_tx("pp2", 8'h64); cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    expect_tx("pp3", 8'h55); cyc(1'b0, A_STATUS, 32'h0, 1'b1);
    check("pp_empty", {31'b0, tx_valid}, 32'h0);

    // Reset while bytes are pending discards them at once.
    cyc(1'b1, A_TX, 32'h77, 1'b0);
    cyc(1'b1, A_TX, 32'h78, 1'b0);
    check("pending_valid", {31'b0, tx_valid}, 32'h1);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, tx_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_reset();
    peek("rst_mid_status", A_STATUS, 32'h0000_0001);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic        w;
      if ($urandom_range(0, 1) == 0)
        a = (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 3)) << 12)
            | 32'($urandom_range(0, 3));
      else
        a = 32'hFFFF_0000 | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
      w = ($urandom_range(0, 9) < 4);
      cyc(w, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
